// File: rtl/spi_pkg.sv
// Shared types and default constants for the SPI configuration minion.
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        CHECK = 2'd2
    } spi_state_t;

    localparam int   SPI_SYNC_STAGES = 2;
    localparam logic SPI_CS_IDLE     = 1'b1;

endpackage

// File: rtl/spi_sync_edge.sv
// N-stage synchronizer for one asynchronous pin, with rise/fall pulses
// derived from the last stage and one extra registered copy.
module spi_sync_edge #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q, sync_d;
    logic              prev_q, prev_d;

    // next values for the synchronizer chain and the edge-detect copy
    always_comb begin
        sync_d = {sync_q[STAGES-2:0], din};
        prev_d = sync_q[STAGES-1];
    end

    // synchronizer and edge-detect registers, reset to the pin's idle level
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= {STAGES{RST_VAL}};
            prev_q <= RST_VAL;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign level = sync_q[STAGES-1];
    assign rise  = level & ~prev_q;
    assign fall  = ~level & prev_q;

endmodule

// File: rtl/spi_control_minion.sv
// SPI mode-0 minion: receives fixed-length frames, presents them as a
// val/rdy message and echoes the last delivered word back on miso.
module spi_control_minion
    import spi_pkg::*;
#(
    parameter int MSG_WIDTH   = 8,
    parameter int SYNC_STAGES = SPI_SYNC_STAGES
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cs,
    input  logic                 sclk,
    input  logic                 mosi,
    output logic                 miso,
    output logic [MSG_WIDTH-1:0] send_msg,
    output logic                 send_val,
    input  logic                 send_rdy,
    output logic                 overflow
);

    localparam int CW = $clog2(MSG_WIDTH + 2);
    localparam int WW = $clog2(SYNC_STAGES + 1);
    localparam logic [CW-1:0] CNT_FULL  = CW'(MSG_WIDTH);
    localparam logic [CW-1:0] CNT_SAT   = CW'(MSG_WIDTH + 1);
    localparam logic [WW-1:0] WARM_DONE = WW'(SYNC_STAGES);

    logic cs_level, cs_rise, cs_fall;
    logic sclk_level_unused, sclk_rise, sclk_fall;
    logic mosi_level, mosi_rise_unused, mosi_fall_unused;

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(SPI_CS_IDLE)) u_cs_sync (
        .clk(clk), .reset(reset), .din(cs),
        .level(cs_level), .rise(cs_rise), .fall(cs_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk_sync (
        .clk(clk), .reset(reset), .din(sclk),
        .level(sclk_level_unused), .rise(sclk_rise), .fall(sclk_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_mosi_sync (
        .clk(clk), .reset(reset), .din(mosi),
        .level(mosi_level), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
    );

    spi_state_t           state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [MSG_WIDTH-1:0] rx_q, rx_d;
    logic [MSG_WIDTH-1:0] tx_q, tx_d;
    logic [MSG_WIDTH-1:0] echo_q, echo_d;
    logic [MSG_WIDTH-1:0] msg_q, msg_d;
    logic                 val_q, val_d;
    logic                 ovf_q, ovf_d;
    logic                 miso_q, miso_d;
    logic [WW-1:0]        warm_q, warm_d;
    logic                 armed_q, armed_d;
    logic                 buf_free;

    // Frames are only accepted once a real cs-high level has been seen after
    // the synchronizers have refilled, so a cs held low through reset never
    // produces a false fall and a partial frame.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rx_d     = rx_q;
        tx_d     = tx_q;
        echo_d   = echo_q;
        msg_d    = msg_q;
        val_d    = val_q;
        ovf_d    = ovf_q;
        warm_d   = warm_q;
        armed_d  = armed_q;
        miso_d   = 1'b0;
        buf_free = ~val_q | send_rdy;

        if (warm_q == WARM_DONE) begin
            armed_d = armed_q | cs_level;
        end else begin
            warm_d = warm_q + WW'(1);
        end

        if (val_q && send_rdy) begin
            val_d  = 1'b0;
            echo_d = msg_q;
        end else begin
            val_d  = val_q;
        end

        case (state_q)
            IDLE: begin
                if (cs_fall && armed_q) begin
                    cnt_d   = '0;
                    tx_d    = echo_q;
                    state_d = SHIFT;
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                if (cs_rise) begin
                    state_d = CHECK;
                end else if (sclk_rise) begin
                    rx_d  = {rx_q[MSG_WIDTH-2:0], mosi_level};
                    cnt_d = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + CW'(1);
                end else if (sclk_fall) begin
                    tx_d = {tx_q[MSG_WIDTH-2:0], 1'b0};
                end else begin
                    state_d = SHIFT;
                end
            end
            CHECK: begin
                state_d = IDLE;
                if (cnt_q == CNT_FULL) begin
                    if (buf_free) begin
                        msg_d = rx_q;
                        val_d = 1'b1;
                    end else begin
                        ovf_d = 1'b1;
                    end
                end else begin
                    ovf_d = ovf_q;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (state_d == SHIFT) begin
            miso_d = tx_d[MSG_WIDTH-1];
        end else begin
            miso_d = 1'b0;
        end
    end

    // state, datapath and registered output flops
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rx_q    <= '0;
            tx_q    <= '0;
            echo_q  <= '0;
            msg_q   <= '0;
            val_q   <= 1'b0;
            ovf_q   <= 1'b0;
            miso_q  <= 1'b0;
            warm_q  <= '0;
            armed_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rx_q    <= rx_d;
            tx_q    <= tx_d;
            echo_q  <= echo_d;
            msg_q   <= msg_d;
            val_q   <= val_d;
            ovf_q   <= ovf_d;
            miso_q  <= miso_d;
            warm_q  <= warm_d;
            armed_q <= armed_d;
        end
    end

    assign miso     = miso_q;
    assign send_msg = msg_q;
    assign send_val = val_q;
    assign overflow = ovf_q;

endmodule
